// File: rtl/apb_bridge_pkg.sv
// Shared types and default widths for the asynchronous APB bridge.
// Both sides of the bridge import this package.
package apb_bridge_pkg;

    localparam int APB_ADDR_WD     = 32;
    localparam int APB_DATA_WD     = 32;
    localparam int APB_STRB_WD     = APB_DATA_WD / 8;
    localparam int APB_PROT_WD     = 3;
    localparam int APB_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    typedef struct packed {
        logic                   write;
        logic [APB_ADDR_WD-1:0] addr;
        logic [APB_DATA_WD-1:0] wdata;
        logic [APB_PROT_WD-1:0] prot;
        logic [APB_STRB_WD-1:0] strb;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_WD-1:0] rdata;
        logic                   err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_access_watchdog.sv
// Saturating ACCESS-phase cycle counter for the APB requester.
// `expired` flags the cycle whose clock edge brings the count to LIMIT.
module apb_access_watchdog #(
    parameter int unsigned LIMIT = 16,
    localparam int CNT_WD = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_WD-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CNT_WD'(LIMIT))) begin
            cnt <= cnt + CNT_WD'(1);
        end
    end

    // Counting the saturated value as expired keeps the abort sticky.
    assign expired = enable && ((cnt == CNT_WD'(LIMIT - 1)) || (cnt == CNT_WD'(LIMIT)));

endmodule

// File: rtl/apb_b_req_master.sv
// Destination-side APB requester: one request at a time becomes a SETUP/ACCESS
// transfer on the b_p* bus, with the result returned on a valid/ready response.
module apb_b_req_master
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WD     = APB_ADDR_WD,
    parameter int DATA_WD     = APB_DATA_WD,
    parameter int STRB_WD     = APB_STRB_WD,
    parameter int PROT_WD     = APB_PROT_WD,
    parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
    input  logic               b_pclk,
    input  logic               b_prst,

    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [ADDR_WD-1:0] req_addr,
    input  logic [DATA_WD-1:0] req_wdata,
    input  logic [PROT_WD-1:0] req_prot,
    input  logic [STRB_WD-1:0] req_strb,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_WD-1:0] rsp_rdata,
    output logic               rsp_err,

    output logic               b_psel,
    output logic               b_penable,
    output logic               b_pwrite,
    output logic [ADDR_WD-1:0] b_paddr,
    output logic [DATA_WD-1:0] b_pwdata,
    output logic [PROT_WD-1:0] b_pprot,
    output logic [STRB_WD-1:0] b_pstrb,
    input  logic [DATA_WD-1:0] b_prdata,
    input  logic               b_pready,
    input  logic               b_pslverr
);

    apb_mst_state_e     state;
    logic               wd_expired;

    logic               write_q;
    logic [ADDR_WD-1:0] addr_q;
    logic [DATA_WD-1:0] wdata_q;
    logic [PROT_WD-1:0] prot_q;
    logic [STRB_WD-1:0] strb_q;
    logic [DATA_WD-1:0] rdata_q;
    logic               err_q;

    generate
        if (TIMEOUT_CYC > 0) begin : g_wd
            apb_access_watchdog #(
                .LIMIT(TIMEOUT_CYC)
            ) u_wd (
                .clk    (b_pclk),
                .rst    (b_prst),
                .clear  (state == SETUP),
                .enable (state == ACCESS),
                .expired(wd_expired)
            );
        end else begin : g_no_wd
            assign wd_expired = 1'b0;
        end
    endgenerate

    // Bus handshake outputs are registered here so the async reset drops them at once.
    always_ff @(posedge b_pclk or posedge b_prst) begin
        if (b_prst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            b_psel    <= 1'b0;
            b_penable <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            prot_q    <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        prot_q    <= req_prot;
                        strb_q    <= req_write ? req_strb : '0;
                        req_ready <= 1'b0;
                        b_psel    <= 1'b1;
                        b_penable <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    b_penable <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // Completion is checked first so a ready on the limit edge still wins.
                    if (b_pready) begin
                        rdata_q   <= write_q ? '0 : b_prdata;
                        err_q     <= b_pslverr;
                        b_psel    <= 1'b0;
                        b_penable <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wd_expired) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        b_psel    <= 1'b0;
                        b_penable <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    b_psel    <= 1'b0;
                    b_penable <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign b_pwrite  = write_q;
    assign b_paddr   = addr_q;
    assign b_pwdata  = wdata_q;
    assign b_pprot   = prot_q;
    assign b_pstrb   = strb_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_b_req_master.sv
// Randomised scoreboard bench for apb_b_req_master with an APB slave model.
// Expected responses come from a transaction-level model of the bridge rules.
module tb_apb_b_req_master;
    import apb_bridge_pkg::*;

    localparam int TO = 4;

    logic        b_pclk = 1'b0;
    logic        b_prst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_prot = '0;
    logic [3:0]  req_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        b_psel, b_penable, b_pwrite;
    logic [31:0] b_paddr, b_pwdata;
    logic [2:0]  b_pprot;
    logic [3:0]  b_pstrb;
    logic [31:0] b_prdata = '0;
    logic        b_pready = 1'b0;
    logic        b_pslverr = 1'b0;

    typedef struct {
        int   waits;
        logic err;
    } scfg_t;

    typedef struct {
        apb_rsp_t rsp;
        int       exp_edge;
    } exp_t;

    exp_t        exp_q[$];
    scfg_t       cfg_q[$];
    logic [31:0] m_mem[logic [31:0]];
    logic [31:0] s_mem[logic [31:0]];
    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;
    bit          hold_low = 1'b0;
    bit          rsp_active = 1'b0;

    apb_b_req_master #(
        .ADDR_WD(32), .DATA_WD(32), .STRB_WD(4), .PROT_WD(3), .TIMEOUT_CYC(TO)
    ) dut (
        .b_pclk(b_pclk), .b_prst(b_prst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_prot(req_prot), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .b_psel(b_psel), .b_penable(b_penable), .b_pwrite(b_pwrite),
        .b_paddr(b_paddr), .b_pwdata(b_pwdata), .b_pprot(b_pprot), .b_pstrb(b_pstrb),
        .b_prdata(b_prdata), .b_pready(b_pready), .b_pslverr(b_pslverr)
    );

    always #5 b_pclk = ~b_pclk;

    always @(posedge b_pclk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic failNow(input string nm);
        tests++;
        failed++;
        $display("[TB] FAIL %s (t=%0t)", nm, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] res = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[b*8 +: 8] = wd[b*8 +: 8];
        return res;
    endfunction

    // Transaction-level model: a stalled slave past the limit aborts, otherwise the slave answers.
    function automatic apb_rsp_t modelAccess(input apb_req_t r, input int waits, input logic err);
        apb_rsp_t rsp;
        if (waits >= TO) begin
            rsp.rdata = '0;
            rsp.err   = 1'b1;
        end else if (r.write) begin
            rsp.rdata = '0;
            rsp.err   = err;
            if (!err) m_mem[r.addr] = merge(m_mem.exists(r.addr) ? m_mem[r.addr] : 32'h0, r.wdata, r.strb);
        end else begin
            rsp.rdata = m_mem.exists(r.addr) ? m_mem[r.addr] : 32'h0;
            rsp.err   = err;
        end
        return rsp;
    endfunction

    task automatic applyStimulus(input apb_req_t r, input int waits, input logic err);
        bit   accepted = 1'b0;
        exp_t e;
        scfg_t c;
        req_write = r.write;
        req_addr  = r.addr;
        req_wdata = r.wdata;
        req_prot  = r.prot;
        req_strb  = r.strb;
        req_valid = 1'b1;
        for (int i = 0; i < 300 && !accepted; i++) begin
            if (req_ready) begin
                accepted   = 1'b1;
                e.rsp      = modelAccess(r, waits, err);
                e.exp_edge = cyc + 1 + 1 + ((waits < TO) ? waits + 1 : TO);
                exp_q.push_back(e);
                c.waits = waits;
                c.err   = err;
                cfg_q.push_back(c);
            end
            @(negedge b_pclk);
        end
        if (!accepted) failNow("accept_timeout");
        // Garbage request while busy must be ignored.
        req_write = $urandom_range(0, 1);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_strb  = 4'hF;
        @(negedge b_pclk);
        req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_active) && n < 500) begin
            @(negedge b_pclk);
            n++;
        end
        if (n >= 500) failNow("drain_timeout");
    endtask

    // APB slave: programmable wait states and error per transfer, plus bus stability checks.
    logic [31:0] s_addr, s_wdata, c_addr, c_wdata;
    logic        s_write, c_write, c_err, commit_pend = 1'b0;
    logic [3:0]  c_strb;
    int          acc_cnt = 0;
    scfg_t       s_cfg;

    always @(negedge b_pclk) begin
        if (b_prst) begin
            acc_cnt     = 0;
            commit_pend = 1'b0;
            b_pready    = 1'b0;
            b_pslverr   = 1'b0;
        end else begin
            if (commit_pend) begin
                if (c_write && !c_err)
                    s_mem[c_addr] = merge(s_mem.exists(c_addr) ? s_mem[c_addr] : 32'h0, c_wdata, c_strb);
                commit_pend = 1'b0;
            end
            b_prdata = $urandom;
            if (b_psel && !b_penable) begin
                if (cfg_q.size() != 0) begin
                    s_cfg = cfg_q.pop_front();
                end else begin
                    failNow("unexpected_setup");
                    s_cfg.waits = 0;
                    s_cfg.err   = 1'b0;
                end
                acc_cnt   = 0;
                s_addr    = b_paddr;
                s_wdata   = b_pwdata;
                s_write   = b_pwrite;
                b_pready  = 1'b0;
                b_pslverr = 1'b0;
                if (!b_pwrite) checkOutput("read_pstrb_setup", {28'h0, b_pstrb}, 32'h0);
            end else if (b_psel && b_penable) begin
                acc_cnt++;
                checkOutput("paddr_stable", b_paddr, s_addr);
                checkOutput("pwdata_stable", b_pwdata, s_wdata);
                checkOutput("pwrite_stable", {31'h0, b_pwrite}, {31'h0, s_write});
                if (!b_pwrite) checkOutput("read_pstrb_access", {28'h0, b_pstrb}, 32'h0);
                b_pready  = (acc_cnt > s_cfg.waits);
                b_pslverr = b_pready & s_cfg.err;
                if (b_pready) begin
                    if (!b_pwrite) b_prdata = s_mem.exists(b_paddr) ? s_mem[b_paddr] : 32'h0;
                    commit_pend = 1'b1;
                    c_addr  = b_paddr;
                    c_wdata = b_pwdata;
                    c_strb  = b_pstrb;
                    c_write = b_pwrite;
                    c_err   = s_cfg.err;
                end
            end else begin
                b_pready  = 1'b0;
                b_pslverr = 1'b0;
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response and drives rsp_ready.
    exp_t cur;
    bit   cur_ok = 1'b0;

    always @(negedge b_pclk) begin
        if (b_prst) begin
            rsp_ready  = 1'b0;
            rsp_active = 1'b0;
        end else begin
            if (rsp_valid) begin
                if (!rsp_active) begin
                    if (exp_q.size() == 0) begin
                        failNow("unexpected_rsp");
                        cur_ok = 1'b0;
                    end else begin
                        cur    = exp_q.pop_front();
                        cur_ok = 1'b1;
                        checkOutput("rsp_rdata", rsp_rdata, cur.rsp.rdata);
                        checkOutput("rsp_err", {31'h0, rsp_err}, {31'h0, cur.rsp.err});
                        checkOutput("rsp_latency", cyc, cur.exp_edge);
                    end
                    rsp_active = 1'b1;
                end else if (cur_ok) begin
                    checkOutput("rsp_rdata_hold", rsp_rdata, cur.rsp.rdata);
                    checkOutput("rsp_err_hold", {31'h0, rsp_err}, {31'h0, cur.rsp.err});
                end
                checkOutput("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
                checkOutput("psel_in_resp", {31'h0, b_psel}, 32'h0);
            end
            rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (rsp_valid && rsp_ready) rsp_active = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        apb_req_t r;
        int       waits;
        int       n;
        int       wsel[7] = '{0, 0, 1, 2, 3, 4, 6};

        repeat (3) @(posedge b_pclk);
        #2 b_prst = 1'b0;
        @(negedge b_pclk);
        checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("rst_psel", {31'h0, b_psel}, 32'h0);
        checkOutput("rst_penable", {31'h0, b_penable}, 32'h0);
        checkOutput("rst_paddr", b_paddr, 32'h0);
        checkOutput("rst_pstrb", {28'h0, b_pstrb}, 32'h0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_rsp_err", {31'h0, rsp_err}, 32'h0);

        r = '{write: 1'b1, addr: 32'h10, wdata: 32'hDEADBEEF, prot: 3'h2, strb: 4'hF};
        applyStimulus(r, 0, 1'b0);
        waitDrain();
        checkOutput("mem_0x10", s_mem.exists(32'h10) ? s_mem[32'h10] : 32'h0, 32'hDEADBEEF);
        r = '{write: 1'b0, addr: 32'h10, wdata: 32'h0, prot: 3'h0, strb: 4'hF};
        applyStimulus(r, 0, 1'b0);
        r = '{write: 1'b1, addr: 32'h14, wdata: 32'h12345678, prot: 3'h1, strb: 4'h5};
        applyStimulus(r, 3, 1'b0);
        r = '{write: 1'b0, addr: 32'h14, wdata: 32'h0, prot: 3'h0, strb: 4'h0};
        applyStimulus(r, 3, 1'b0);
        r = '{write: 1'b0, addr: 32'h10, wdata: 32'h0, prot: 3'h0, strb: 4'h0};
        applyStimulus(r, 100, 1'b0);
        r = '{write: 1'b1, addr: 32'h18, wdata: 32'hCAFEF00D, prot: 3'h0, strb: 4'hF};
        applyStimulus(r, 1, 1'b1);
        waitDrain();

        hold_low = 1'b1;
        r = '{write: 1'b0, addr: 32'h10, wdata: 32'h0, prot: 3'h0, strb: 4'h0};
        applyStimulus(r, 0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge b_pclk);
            n++;
        end
        if (n >= 50) failNow("bp_rsp_timeout");
        repeat (5) @(negedge b_pclk);
        hold_low = 1'b0;
        waitDrain();

        r = '{write: 1'b1, addr: 32'h1C, wdata: 32'h55AA55AA, prot: 3'h0, strb: 4'hF};
        req_write = r.write; req_addr = r.addr; req_wdata = r.wdata; req_strb = r.strb;
        req_valid = 1'b1;
        @(negedge b_pclk);
        req_valid = 1'b0;
        cfg_q.push_back('{waits: 10, err: 1'b0});
        n = 0;
        while (!(b_psel && b_penable) && n < 20) begin
            @(negedge b_pclk);
            n++;
        end
        if (n >= 20) failNow("reset_access_timeout");
        #2 b_prst = 1'b1;
        #1;
        checkOutput("rst_async_psel", {31'h0, b_psel}, 32'h0);
        checkOutput("rst_async_penable", {31'h0, b_penable}, 32'h0);
        exp_q.delete();
        cfg_q.delete();
        @(posedge b_pclk);
        #2 b_prst = 1'b0;
        @(negedge b_pclk);
        checkOutput("rst_release_req_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("rst_release_rsp_valid", {31'h0, rsp_valid}, 32'h0);

        for (int i = 0; i < 60; i++) begin
            r.write = $urandom_range(0, 1);
            r.addr  = 32'h10 + 32'($urandom_range(0, 7) * 4);
            r.wdata = $urandom;
            r.prot  = 3'($urandom_range(0, 7));
            r.strb  = 4'($urandom_range(0, 15));
            waits   = wsel[$urandom_range(0, 6)];
            applyStimulus(r, waits, $urandom_range(0, 5) == 0);
        end
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/apb_b_req_master.md
# apb_b_req_master

Destination-domain APB requester for the asynchronous APB bridge: takes one already-synchronised transfer request at a time on a valid/ready interface, drives it on the b-side APB bus as a SETUP/ACCESS sequence, and returns read data and error status on a valid/ready response interface. It sits directly upstream of the b-side APB slave memory, between the bridge's CDC request/response path and the `b_p*` bus. It adds an optional access-phase watchdog.

## Interface
- `ADDR_WD`, 32, APB address width
- `DATA_WD`, 32, APB data width
- `STRB_WD`, 4, write strobe width (`DATA_WD/8`)
- `PROT_WD`, 3, `pprot` width
- `TIMEOUT_CYC`, 16, maximum ACCESS cycles before abort; 0 disables the watchdog
- `b_pclk` in 1: sole clock
- `b_prst` in 1: reset, asynchronous, active-high
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted when both high
- `req_write` in 1: 1 = write, 0 = read
- `req_addr` in `ADDR_WD`; `req_wdata` in `DATA_WD`; `req_prot` in `PROT_WD`; `req_strb` in `STRB_WD`
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: response consumed when both high
- `rsp_rdata` out `DATA_WD`: read data (0 for writes and timeouts)
- `rsp_err` out 1: `b_pslverr` captured, or watchdog abort
- `b_psel`, `b_penable`, `b_pwrite` out 1
- `b_paddr` out `ADDR_WD`; `b_pwdata` out `DATA_WD`; `b_pprot` out `PROT_WD`; `b_pstrb` out `STRB_WD`
- `b_prdata` in `DATA_WD`; `b_pready` in 1
- `b_pslverr` in 1: slaves without an error output tie it to 0

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`: register write, address, wdata, prot, strb; go to SETUP. Reads force the registered `pstrb` to 0.
- SETUP: `b_psel`=1, `b_penable`=0. Always advances to ACCESS after one cycle.
- ACCESS: `b_psel`=1, `b_penable`=1. The watchdog counter increments each cycle.
  - `b_pready`=1: capture `b_prdata` into `rsp_rdata` (reads only; 0 for writes) and `b_pslverr` into `rsp_err`; go to RESP.
  - `b_pready`=0 and the counter reaches `TIMEOUT_CYC` (if nonzero): `rsp_rdata`=0, `rsp_err`=1; go to RESP.
- RESP: `b_psel`=`b_penable`=0, `rsp_valid`=1, response held stable. On `rsp_ready`, go to IDLE. `req_ready` stays 0 until IDLE.
- `b_paddr`, `b_pwrite`, `b_pwdata`, `b_pprot`, `b_pstrb` come from the request registers and are stable from SETUP through the end of ACCESS. They hold their last value in IDLE/RESP.
- Watchdog counter: width `$clog2(TIMEOUT_CYC+1)`. Cleared on entry to SETUP. Saturates and never wraps.

## Timing
- Reset values: state IDLE, all outputs 0 except `req_ready`=1, all request and response registers 0.
- Reset asserted mid-transfer: immediate return to IDLE, `b_psel`/`b_penable` drop asynchronously, in-flight transfer and pending response discarded.
- Request accepted at edge N:
  - SETUP during cycle N+1.
  - ACCESS from N+2.
  - With zero-wait `b_pready`, `rsp_valid` is high from edge N+3.
- Each `b_pready`-low cycle adds one cycle of latency.
- Minimum issue interval: 4 cycles per transfer with `rsp_ready` held high; no overlap between transfers.
- Timeout: with `b_pready` stuck low, the abort edge is the `TIMEOUT_CYC`-th ACCESS cycle, and `rsp_valid` is high from the following cycle.
- `b_pready` sampled high on the same edge the counter reaches the limit: completion wins and `rsp_err` = `b_pslverr`.
- `rsp_ready` high with no `rsp_valid` has no effect.
- `req_valid` outside IDLE is ignored and not captured.

## Structure
- Shared package `apb_bridge_pkg` holds:
  - state enum `apb_mst_state_e` (IDLE/SETUP/ACCESS/RESP);
  - request and response packed structs parameterised by the width localparams;
  - default width constants.
- One sub-module, `apb_access_watchdog`: saturating counter with clear, enable, and `expired` output, instantiated only when `TIMEOUT_CYC` > 0.

## Test plan
- Write: `req` write, addr 0x10, wdata 0xDEADBEEF, strb 0xF; slave zero-wait. Expect SETUP at N+1, ACCESS at N+2, `rsp_valid` at N+3 with `rsp_err`=0; memory[0x10]=0xDEADBEEF.
- Read after write to 0x10 → `rsp_rdata`=0xDEADBEEF; `b_pstrb`=0 throughout the read.
- Wait states: `b_pready` low for 3 ACCESS cycles → `rsp_valid` at N+6; address and data stable all cycles.
- Timeout: `TIMEOUT_CYC`=4, `b_pready` stuck 0 → abort after 4 ACCESS cycles, `rsp_err`=1, `rsp_rdata`=0, `b_psel` low.
- Backpressure and reset: hold `rsp_ready`=0 for 5 cycles → response stable and `req_ready`=0; then assert `b_prst` during ACCESS of the next transfer → `b_psel`=0 immediately, `req_ready`=1 after release.
- Error capture: `b_pslverr`=1 with `b_pready` → `rsp_err`=1, transfer completes normally.
